dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of dmem. Shares the single dmem port between the core load/store path (port 0) and a debug/loader master (port 1). Issues dmem r_enable/w_enable pulses, waits for read ready, and returns data and a one-cycle ack to the granted requester. Round-robin arbitration by default.

Parameters:
ADDR_W, `ADDR_SIZE+1, byte address width, identical to dmem addr
DATA_W, `INSTR_SIZE+1, data word width, identical to dmem r_data/w_data

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
p0_req  in  1  port 0 request; held with p0_we/addr/wdata stable until p0_ack
p0_we  in  1  port 0: 1 = write, 0 = read
p0_addr  in  ADDR_W  port 0 byte address
p0_wdata  in  DATA_W  port 0 write data
p0_ack  out  1  port 0 one-cycle completion pulse
p0_rdata  out  DATA_W  port 0 read data, valid while p0_ack=1
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1
m_addr  out  ADDR_W  to dmem addr
m_r_enable  out  1  to dmem r_enable
m_w_enable  out  1  to dmem w_enable
m_w_data  out  DATA_W  to dmem w_data
m_r_data  in  DATA_W  from dmem r_data
m_ready  in  1  from dmem ready
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all outputs 0 (m_addr, m_w_data, p*_rdata = 0), last_gnt=1 so port 0 wins first contention.
- All outputs registered or decoded from registered state only; no combinational path from p*_req to m_*.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: at clock edge with any req, pick winner, latch winner addr/we/wdata/id into m_addr/m_w_data/op/gnt_id, set m_r_enable=!we or m_w_enable=we, update last_gnt -> ISSUE. No req: stay.
- ISSUE: enables high exactly one cycle. At next edge clear both enables; write -> RESP; read -> WAIT.
- WAIT: at edge with m_ready=1, capture m_r_data into granted port rdata register -> RESP. m_ready=0: stay (no timeout unless option enabled).
- RESP: p<gnt_id>_ack=1 for exactly this cycle; other port ack=0. Requester must drop or change req before the next edge. Next edge -> IDLE. A new request is sampled no earlier than the IDLE cycle that follows.
- Latency from the edge sampling req: write ack visible 2 cycles later; read ack 3 cycles later (m_ready arriving on first WAIT cycle). Back-to-back throughput: one transaction per 3 (write) / 4 (read) cycles.
- Arbitration: one req -> that port. Both -> port != last_gnt. Losing port's req is held; it wins the next IDLE sample.
- Non-granted port's rdata holds its previous value.
- Reset mid-operation: enables drop immediately. A write in ISSUE before the dmem edge is lost. No ack is issued and no transaction is replayed.
- Address is passed through unmodified; dmem uses bits [ADDR_W-1:2]. No misalignment checking.

Optional Feature:
DMEM_ARB_FIXED_PRIO_EN
- Defined: port 0 always wins contention and last_gnt is unused. Port 1 may starve.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Shared include (def_params.v): state encodings ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_RESP (2-bit) and port id constants ARB_P0/ARB_P1.
- ADDR_SIZE/INSTR_SIZE come from the same file.
- Natural sub-module: rr_arb2, a combinational 2-way grant picker (req[1:0], last_gnt, fixed_prio -> gnt_id). It is reusable for an imem/dmem bus later.

Test Plan:
- Port 0 write addr 0x08 data 0xDEADBEEF, then read 0x08 -> m_w_enable 1 cycle; p0_ack 2 cycles after req edge; read p0_ack 3 cycles after, with p0_rdata=0xDEADBEEF.
- p0 and p1 both read from reset (0x04, 0x0C) -> p0 served first, then p1; acks never overlap; each rdata matches preloaded dmem.
- Both hold continuous reads for 6 transactions -> grants alternate 0,1,0,1,0,1. With DMEM_ARB_FIXED_PRIO_EN, all 6 go to port 0 and port 1 gets none.
- Hold m_ready low 5 cycles in WAIT (stub dmem) -> busy stays 1, no ack, enables stay 0. Ack follows ready by 1 cycle.
- Assert reset low during ISSUE of a write to 0x10 -> m_w_enable=0 immediately, state IDLE, no ack, dmem[0x10>>2] unchanged.
- p1 write completes while p0 idle -> p0_ack never pulses and p0_rdata keeps its prior value.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the dmem arbiter: word/address sizes, FSM state
// encodings and port identifiers.
package dmem_arbiter_pkg;

    localparam int ADDR_SIZE  = 15;
    localparam int INSTR_SIZE = 31;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10,
        ARB_RESP  = 2'b11
    } arb_state_e;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way grant picker: round-robin against last_gnt, or
// fixed priority to port 0 when fixed_prio is set.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       fixed_prio,
    output logic       gnt_id
);

    // Pick the winning port id from the current request vector.
    always_comb begin
        gnt_id = ARB_P0;
        case (req)
            2'b01:   gnt_id = ARB_P0;
            2'b10:   gnt_id = ARB_P1;
            2'b11: begin
                if (fixed_prio) begin
                    gnt_id = ARB_P0;
                end else begin
                    gnt_id = ~last_gnt;
                end
            end
            default: gnt_id = ARB_P0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer sharing the single dmem port between the core
// (port 0) and a debug/loader master (port 1). Optional build macro:
// DMEM_ARB_FIXED_PRIO_EN selects fixed priority to port 0 instead of round-robin.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_SIZE + 1,
    parameter int DATA_W = INSTR_SIZE + 1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_r_enable,
    output logic              m_w_enable,
    output logic [DATA_W-1:0] m_w_data,
    input  logic [DATA_W-1:0] m_r_data,
    input  logic              m_ready,
    output logic              busy
);

    arb_state_e        state_r;
    arb_state_e        state_s;
    logic              gnt_s;
    logic              gnt_id_r;
    logic              op_we_r;
    logic              last_gnt_r;
    logic              any_req_s;
    logic              fixed_prio_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign fixed_prio_s = 1'b1;
`else
    assign fixed_prio_s = 1'b0;
`endif

    assign any_req_s = p0_req | p1_req;

    rr_arb2 u_rr_arb2 (
        .req        ({p1_req, p0_req}),
        .last_gnt   (last_gnt_r),
        .fixed_prio (fixed_prio_s),
        .gnt_id     (gnt_s)
    );

    // Route the winning port's command fields toward the latch stage.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (gnt_s == ARB_P1) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Next-state decode for the IDLE/ISSUE/WAIT/RESP sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (any_req_s) begin
                    state_s = ARB_ISSUE;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (op_we_r) begin
                    state_s = ARB_RESP;
                end else begin
                    state_s = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (m_ready) begin
                    state_s = ARB_RESP;
                end else begin
                    state_s = ARB_WAIT;
                end
            end
            ARB_RESP: state_s = ARB_IDLE;
            default:  state_s = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command latch, dmem strobes, read-data capture and registered acks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_id_r   <= ARB_P0;
            op_we_r    <= 1'b0;
            last_gnt_r <= ARB_P1;
            m_addr     <= '0;
            m_w_data   <= '0;
            m_r_enable <= 1'b0;
            m_w_enable <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (any_req_s) begin
                        gnt_id_r   <= gnt_s;
                        op_we_r    <= sel_we_s;
                        last_gnt_r <= gnt_s;
                        m_addr     <= sel_addr_s;
                        m_w_data   <= sel_wdata_s;
                        m_r_enable <= ~sel_we_s;
                        m_w_enable <= sel_we_s;
                    end
                end
                ARB_ISSUE: begin
                    m_r_enable <= 1'b0;
                    m_w_enable <= 1'b0;
                end
                ARB_WAIT: begin
                    // Only the granted port's rdata moves; the other holds.
                    if (m_ready) begin
                        if (gnt_id_r == ARB_P1) begin
                            p1_rdata <= m_r_data;
                        end else begin
                            p0_rdata <= m_r_data;
                        end
                    end
                end
                ARB_RESP: begin
                    m_r_enable <= 1'b0;
                    m_w_enable <= 1'b0;
                end
                default: begin
                    m_r_enable <= 1'b0;
                    m_w_enable <= 1'b0;
                end
            endcase
            p0_ack <= (state_s == ARB_RESP) && (gnt_id_r == ARB_P0);
            p1_ack <= (state_s == ARB_RESP) && (gnt_id_r == ARB_P1);
            busy   <= (state_s != ARB_IDLE);
        end
    end

endmodule
